// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern, overlap select,
// valid qualification and a match counter built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int             PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011,
  parameter int             CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ip,
  input  logic             ip_vld,
  input  logic             ovl_mode,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             op,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  // FILL/ARMED is a view of the fill counter, not a separate register.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [PAT_W-1:0] hist, hist_next, hist_shift;
  logic [FW-1:0]    fill, fill_next, fill_inc;
  logic             op_next;
  logic             match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg <= DEFAULT_PAT;
      hist    <= '0;
      fill    <= '0;
      op      <= 1'b0;
    end else begin
      pat_reg <= pat_next;
      hist    <= hist_next;
      fill    <= fill_next;
      op      <= op_next;
    end
  end

  always_comb begin
    hist_shift = {hist[PAT_W-2:0], ip};
    fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
    match      = (fill_inc == FULL) && (hist_shift == pat_reg);

    pat_next  = pat_reg;
    hist_next = hist;
    fill_next = fill;
    op_next   = 1'b0;

    if (pat_ld) begin
      pat_next  = pat_in;
      hist_next = '0;
      fill_next = '0;
    end else if (ip_vld) begin
      hist_next = hist_shift;
      op_next   = match;
      // Non-overlapping mode restarts the fill so the matched bits cannot be reused.
      fill_next = (match && !ovl_mode) ? '0 : fill_inc;
    end

    state = (fill == FULL) ? ARMED : FILL;
    armed = (state == ARMED);
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear wins over a simultaneous match; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (op_next && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: vector tables checked through an expected-value queue,
// plus hand-written asynchronous reset and saturation sequences.
module tb_seq_detect_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             ip;
  logic             ip_vld;
  logic             ovl_mode;
  logic             pat_ld;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             op;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  int checks;
  int failures;

  // Expected {op, armed, match_cnt} per driven cycle.
  logic [CNT_W+1:0] exp_q[$];

  typedef struct {
    logic             ip;
    logic             vld;
    logic             ovl;
    logic             ld;
    logic [PAT_W-1:0] pat;
    logic             clr;
    logic             e_op;
    logic             e_armed;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t tab[$];

  seq_detect_param #(
    .PAT_W      (PAT_W),
    .DEFAULT_PAT(4'b1011),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ip       (ip),
    .ip_vld   (ip_vld),
    .ovl_mode (ovl_mode),
    .pat_ld   (pat_ld),
    .pat_in   (pat_in),
    .cnt_clr  (cnt_clr),
    .op       (op),
    .match_cnt(match_cnt),
    .armed    (armed)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CNT_W-1:0] cnt_model(input logic [CNT_W-1:0] c);
`ifdef SEQDET_MATCH_CNT_EN
    return c;
`else
    return '0;
`endif
  endfunction

  function automatic vec_t mk(input logic i, input logic v, input logic o, input logic l,
                              input logic [PAT_W-1:0] p, input logic c,
                              input logic eo, input logic ea, input logic [CNT_W-1:0] ec);
    vec_t r;
    r.ip = i; r.vld = v; r.ovl = o; r.ld = l; r.pat = p; r.clr = c;
    r.e_op = eo; r.e_armed = ea; r.e_cnt = ec;
    return r;
  endfunction

  task automatic check_now(input string name, input logic [CNT_W+1:0] exp);
    logic [CNT_W+1:0] got;
    got = {op, armed, match_cnt};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got op/armed/cnt=%b/%b/%0d, required %b/%b/%0d",
               name, got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
               exp[CNT_W+1], exp[CNT_W], exp[CNT_W-1:0]);
    end
  endtask

  // Driver: one clock per vector; expectation queued when driven, popped after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [CNT_W+1:0] exp;
    @(negedge clk);
    ip = v.ip; ip_vld = v.vld; ovl_mode = v.ovl; pat_ld = v.ld; pat_in = v.pat; cnt_clr = v.clr;
    exp_q.push_back({v.e_op, v.e_armed, cnt_model(v.e_cnt)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_now(name, exp);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("%s[%0d]", name, i));
    tab.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ip = 1'b0; ip_vld = 1'b0; ovl_mode = 1'b0;
    pat_ld = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; ip = 1'b0; ip_vld = 1'b0; ovl_mode = 1'b0;
    pat_ld = 1'b0; pat_in = '0; cnt_clr = 1'b0;

    // Overlapping, 1011 in 1,0,1,1,0,1,1: matches after bits 4 and 7
    do_reset();
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1));
    tab.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 2));
    run_table("ovl");

    // Non-overlapping: only bit 4 matches, armed drops after it
    do_reset();
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    run_table("novl");

    // Idle cycles between valid bits hold history and keep op low
    do_reset();
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1));
    tab.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1));
    run_table("gap");

    // Pattern load mid-stream with a same-cycle valid bit that must be ignored
    do_reset();
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 1, 4'b1100, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0,       0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0,       0, 1, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 1, 1));
    tab.push_back(mk(0, 1, 1, 0, 0,       0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0,       0, 0, 1, 1));
    run_table("load");

    // Asynchronous reset between edges clears state immediately
    do_reset();
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 1));
    tab.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 1));
    run_table("pre_arst");
    #2 rst = 1'b0;
    #1 check_now("async_reset", '0);
    #2 rst = 1'b1;
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), "post_arst_bit");

    // All-ones pattern: back-to-back pulses, saturation at 3, clear beats match
    do_reset();
    apply(mk(0, 0, 1, 1, 4'b1111, 0, 0, 0, 0), "sat_load");
    for (int i = 1; i <= 7; i++) begin
      apply(mk(1, 1, 1, 0, 0, 0, (i >= 4), (i >= 4), (i >= 6) ? 2'd3 : (i == 5) ? 2'd2 :
               (i == 4) ? 2'd1 : 2'd0), $sformatf("sat_bit%0d", i));
    end
    apply(mk(1, 1, 1, 0, 0, 1, 1, 1, 0), "clr_vs_match");
    apply(mk(1, 1, 1, 0, 0, 0, 1, 1, 1), "after_clr");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
